vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
Generates VGA raster timing (Hsync, Vsync, DE) plus pixel coordinates and a linear frame-buffer address from a pixel-rate clock enable. It drives the display side and is the transmitter end of the Hsync/Vsync interface consumed by our BRAM address controller. It runs on CLK, so the bench can loop its syncs straight into the controller.

Parameters:
HSIZE, 640, active pixels per line
HFP, 16, horizontal front porch (pixels)
HSW, 96, horizontal sync width (pixels)
HBP, 48, horizontal back porch (pixels)
VSIZE, 480, active lines per frame
VFP, 10, vertical front porch (lines)
VSW, 2, vertical sync width (lines)
VBP, 33, vertical back porch (lines)

Ports:
CLK  in  1  pixel-domain clock
RESET  in  1  asynchronous, active-high reset
ce  in  1  pixel clock enable; timing advances only when high
hsync  out  1  horizontal sync, active-low
vsync  out  1  vertical sync, active-low
de  out  1  data enable, high during active pixels
x  out  11  pixel column, 0..HSIZE-1 in active; HTOTAL-1 max
y  out  11  line number, 0..VTOTAL-1
line_start  out  1  one-cycle pulse, x==0 entered
frame_start  out  1  one-cycle pulse, x==0 and y==0 entered
addr  out  24  linear address y*HSIZE+x

Behaviour:
- HTOTAL=HSIZE+HFP+HSW+HBP (800); VTOTAL=VSIZE+VFP+VSW+VBP (525).
- Line order per axis: ACTIVE [0,HSIZE) -> FRONT_PORCH -> SYNC -> BACK_PORCH -> wrap. Vertical uses the same order over lines.
- Horizontal state machine: states ACTIVE, HFP, HSYNC, HBP, tracked by x. Transitions happen on a ce cycle when x reaches each boundary.
- Vertical state machine: ACTIVE, VFP, VSYNC, VBP. Advances only on the ce cycle where x wraps HTOTAL-1 -> 0.
- All outputs are registered and mutually consistent in the same cycle. hsync, vsync, de and addr always describe the current x,y.
- hsync=0 iff HSIZE+HFP <= x < HSIZE+HFP+HSW.
- vsync=0 iff VSIZE+VFP <= y < VSIZE+VFP+VSW. vsync changes only together with an x wrap.
- de=1 iff x<HSIZE and y<VSIZE.
- ce=0: every output holds its value. line_start and frame_start drop to 0 after one cycle even if ce stays low.
- line_start=1 for exactly the one cycle on which x becomes 0. frame_start=1 when, additionally, y becomes 0.
- addr is computed incrementally; no multiplier.
  - 0 at frame start.
  - +1 per ce cycle while de=1 and the next position is also active.
  - The first active pixel of each line equals the previous line's last active address +1.
  - Holds during blanking.
  - Width rule: max value VSIZE*HSIZE-1 must fit 24 bits; elaboration error otherwise.
- Reset values:
  - x=HTOTAL-1, y=VTOTAL-1, so the first ce after reset wraps to 0,0.
  - hsync=1, vsync=1, de=0, line_start=0, frame_start=0, addr=0.
- First ce after reset release gives x=0, y=0, de=1, addr=0, line_start=1, frame_start=1.
- RESET asserted mid-line: immediate return to reset values. No partial sync pulse is stretched; hsync/vsync go high at once.
- Boundaries: x wrap at HTOTAL-1 -> 0 with y+1. At y==VTOTAL-1, y wraps to 0. Wrap and sync-edge events on the same cycle are all applied together.

Optional Feature:
VGA_TEST_PATTERN_EN
- Defined: adds output rgb[15:0] (RGB565), registered in the same cycle as de.
- rgb=0 when de=0.
- When de=1, eight vertical colour bars of width HSIZE/8, in order: white, yellow, cyan, green, magenta, red, blue, black.
  - white=16'hFFFF, yellow=16'hFFE0, cyan=16'h07FF, green=16'h07E0, magenta=16'hF81F, red=16'hF800, blue=16'h001F, black=16'h0000.
- Undefined: no rgb port, no pattern logic.

Test Plan:
- Reset, then ce=1 continuously -> first cycle x=0, y=0, de=1, frame_start=1. Next frame_start comes exactly 420000 cycles later.
- One line with ce=1 -> de high 640 cycles. hsync low for 96 cycles starting at x=656. line_start period 800 cycles.
- Full frame -> vsync low at lines 490-491 (1600 cycles), asserting on an x=0 cycle. de=0 for y>=480.
- ce toggling 1/0 -> outputs frozen while ce=0. Frame period is 840000 cycles. Pulses are single-cycle.
- addr check:
  - x=639, y=0 -> 639.
  - x=0, y=1 -> 640.
  - last pixel -> 307199, held through blanking.
  - next frame_start -> 0.
- RESET pulse asserted at x=700, y=490 (during hsync and vsync low) -> hsync=1, vsync=1 at once. Restart behaves as the first scenario.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: syncs, data enable, pixel coordinates and linear address, advancing on ce.
// Optional RGB565 colour-bar test pattern on rgb when VGA_TEST_PATTERN_EN is defined.
module vga_timing_gen #(
  parameter int HSIZE = 640,
  parameter int HFP   = 16,
  parameter int HSW   = 96,
  parameter int HBP   = 48,
  parameter int VSIZE = 480,
  parameter int VFP   = 10,
  parameter int VSW   = 2,
  parameter int VBP   = 33
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        ce,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [10:0] x,
  output logic [10:0] y,
  output logic        line_start,
  output logic        frame_start,
  output logic [23:0] addr,
`ifdef VGA_TEST_PATTERN_EN
  output logic [15:0] rgb,
`endif
  output logic [1:0]  o_dbg_hstate,
  output logic [1:0]  o_dbg_vstate
);

  localparam int HTOTAL = HSIZE + HFP + HSW + HBP;
  localparam int VTOTAL = VSIZE + VFP + VSW + VBP;

  localparam logic [10:0] H_ACT_LAST  = 11'(HSIZE - 1);
  localparam logic [10:0] H_FP_LAST   = 11'(HSIZE + HFP - 1);
  localparam logic [10:0] H_SYNC_LAST = 11'(HSIZE + HFP + HSW - 1);
  localparam logic [10:0] H_LAST      = 11'(HTOTAL - 1);
  localparam logic [10:0] V_ACT_LAST  = 11'(VSIZE - 1);
  localparam logic [10:0] V_FP_LAST   = 11'(VSIZE + VFP - 1);
  localparam logic [10:0] V_SYNC_LAST = 11'(VSIZE + VFP + VSW - 1);
  localparam logic [10:0] V_LAST      = 11'(VTOTAL - 1);

  // Every region must be at least one unit wide: each state leaves on its own last position.
  if (VSIZE * HSIZE - 1 > 24'hFF_FFFF) begin : g_bad_addr_width
    $error("vga_timing_gen: VSIZE*HSIZE-1 does not fit the 24-bit addr");
  end
  if (HTOTAL > 2048 || VTOTAL > 2048 || HFP < 1 || HSW < 1 || HBP < 1 ||
      VFP < 1 || VSW < 1 || VBP < 1 || HSIZE < 8 || VSIZE < 1) begin : g_bad_geometry
    $error("vga_timing_gen: unsupported raster geometry");
  end

  typedef enum logic [1:0] {H_ACTIVE = 2'd0, H_FPORCH = 2'd1, H_SYNC = 2'd2, H_BPORCH = 2'd3} h_state_t;
  typedef enum logic [1:0] {V_ACTIVE = 2'd0, V_FPORCH = 2'd1, V_SYNC = 2'd2, V_BPORCH = 2'd3} v_state_t;

  h_state_t    r_hstate, w_hstate_nxt;
  v_state_t    r_vstate, w_vstate_nxt;
  logic [10:0] r_x, r_y, w_x_nxt, w_y_nxt;
  logic [23:0] r_addr, w_addr_nxt;
  logic        r_hsync, r_vsync, r_de, r_line_start, r_frame_start;
  logic        w_x_wrap, w_frame_wrap, w_next_active;

  assign w_x_wrap     = ce && (r_x == H_LAST);
  assign w_frame_wrap = w_x_wrap && (r_y == V_LAST);

  always_comb begin
    w_hstate_nxt = r_hstate;
    if (ce) begin
      case (r_hstate)
        H_ACTIVE: if (r_x == H_ACT_LAST)  w_hstate_nxt = H_FPORCH;
        H_FPORCH: if (r_x == H_FP_LAST)   w_hstate_nxt = H_SYNC;
        H_SYNC:   if (r_x == H_SYNC_LAST) w_hstate_nxt = H_BPORCH;
        H_BPORCH: if (r_x == H_LAST)      w_hstate_nxt = H_ACTIVE;
        default:                          w_hstate_nxt = H_BPORCH;
      endcase
    end
  end

  // The vertical machine only moves on the line wrap, so vsync edges align with x==0.
  always_comb begin
    w_vstate_nxt = r_vstate;
    if (w_x_wrap) begin
      case (r_vstate)
        V_ACTIVE: if (r_y == V_ACT_LAST)  w_vstate_nxt = V_FPORCH;
        V_FPORCH: if (r_y == V_FP_LAST)   w_vstate_nxt = V_SYNC;
        V_SYNC:   if (r_y == V_SYNC_LAST) w_vstate_nxt = V_BPORCH;
        V_BPORCH: if (r_y == V_LAST)      w_vstate_nxt = V_ACTIVE;
        default:                          w_vstate_nxt = V_BPORCH;
      endcase
    end
  end

  always_comb begin
    w_x_nxt = r_x;
    w_y_nxt = r_y;
    if (ce) begin
      w_x_nxt = (r_x == H_LAST) ? 11'd0 : r_x + 11'd1;
    end
    if (w_x_wrap) begin
      w_y_nxt = (r_y == V_LAST) ? 11'd0 : r_y + 11'd1;
    end
  end

  // Address steps into every active pixel, including the first of each line, and holds in blanking.
  assign w_next_active = (w_hstate_nxt == H_ACTIVE) && (w_vstate_nxt == V_ACTIVE);

  always_comb begin
    w_addr_nxt = r_addr;
    if (w_frame_wrap) begin
      w_addr_nxt = 24'd0;
    end else if (ce && w_next_active) begin
      w_addr_nxt = r_addr + 24'd1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_hstate      <= H_BPORCH;
      r_vstate      <= V_BPORCH;
      r_x           <= H_LAST;
      r_y           <= V_LAST;
      r_addr        <= 24'd0;
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_de          <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_hstate      <= w_hstate_nxt;
      r_vstate      <= w_vstate_nxt;
      r_x           <= w_x_nxt;
      r_y           <= w_y_nxt;
      r_addr        <= w_addr_nxt;
      r_hsync       <= (w_hstate_nxt != H_SYNC);
      r_vsync       <= (w_vstate_nxt != V_SYNC);
      r_de          <= w_next_active;
      r_line_start  <= w_x_wrap;
      r_frame_start <= w_frame_wrap;
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  localparam int BAR_W = HSIZE / 8;

  logic [15:0] r_rgb;

  function automatic logic [15:0] bar_colour(input logic [10:0] col);
    logic [2:0] idx;
    idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (col >= 11'(k * BAR_W)) idx = idx + 3'd1;
    end
    case (idx)
      3'd0:    bar_colour = 16'hFFFF;
      3'd1:    bar_colour = 16'hFFE0;
      3'd2:    bar_colour = 16'h07FF;
      3'd3:    bar_colour = 16'h07E0;
      3'd4:    bar_colour = 16'hF81F;
      3'd5:    bar_colour = 16'hF800;
      3'd6:    bar_colour = 16'h001F;
      default: bar_colour = 16'h0000;
    endcase
  endfunction

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_rgb <= 16'h0000;
    end else begin
      r_rgb <= w_next_active ? bar_colour(w_x_nxt) : 16'h0000;
    end
  end

  assign rgb = r_rgb;
`endif

  assign hsync        = r_hsync;
  assign vsync        = r_vsync;
  assign de           = r_de;
  assign x            = r_x;
  assign y            = r_y;
  assign line_start   = r_line_start;
  assign frame_start  = r_frame_start;
  assign addr         = r_addr;
  assign o_dbg_hstate = r_hstate;
  assign o_dbg_vstate = r_vstate;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-geometry instance for line timing and a shrunken
// instance (25 x 9 raster) so whole frames, ce gating and mid-sync reset fit in a short run.
module tb_vga_timing_gen;

  localparam int SM_HSIZE = 16, SM_HFP = 2, SM_HSW = 3, SM_HBP = 4;
  localparam int SM_VSIZE = 4,  SM_VFP = 1, SM_VSW = 2, SM_VBP = 2;
  localparam int SM_HT = 25, SM_VT = 9;

  logic CLK, RESET, ce;

  logic        f_hsync, f_vsync, f_de, f_ls, f_fs;
  logic [10:0] f_x, f_y;
  logic [23:0] f_addr;
  logic [1:0]  f_dbg_h, f_dbg_v;
  logic        s_hsync, s_vsync, s_de, s_ls, s_fs;
  logic [10:0] s_x, s_y;
  logic [23:0] s_addr;
  logic [1:0]  s_dbg_h, s_dbg_v;
`ifdef VGA_TEST_PATTERN_EN
  logic [15:0] f_rgb, s_rgb;
`endif

  int n_checks = 0;
  int n_errors = 0;

  vga_timing_gen dut_full (
    .CLK(CLK), .RESET(RESET), .ce(ce),
    .hsync(f_hsync), .vsync(f_vsync), .de(f_de), .x(f_x), .y(f_y),
    .line_start(f_ls), .frame_start(f_fs), .addr(f_addr),
`ifdef VGA_TEST_PATTERN_EN
    .rgb(f_rgb),
`endif
    .o_dbg_hstate(f_dbg_h), .o_dbg_vstate(f_dbg_v)
  );

  vga_timing_gen #(
    .HSIZE(SM_HSIZE), .HFP(SM_HFP), .HSW(SM_HSW), .HBP(SM_HBP),
    .VSIZE(SM_VSIZE), .VFP(SM_VFP), .VSW(SM_VSW), .VBP(SM_VBP)
  ) dut_small (
    .CLK(CLK), .RESET(RESET), .ce(ce),
    .hsync(s_hsync), .vsync(s_vsync), .de(s_de), .x(s_x), .y(s_y),
    .line_start(s_ls), .frame_start(s_fs), .addr(s_addr),
`ifdef VGA_TEST_PATTERN_EN
    .rgb(s_rgb),
`endif
    .o_dbg_hstate(s_dbg_h), .o_dbg_vstate(s_dbg_v)
  );

  // Clock and reset.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic apply_reset();
    @(negedge CLK);
    RESET = 1'b1;
    ce    = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    ce    = 1'b1;
  endtask

  // Stats for the continuous-ce run.
  int f_de_cnt, f_hs_first, f_hs_cnt, f_ls2;
  int s_fs2, s_fs_cnt, s_vs_first, s_vs_cnt, s_de_cnt, s_de_blank, s_ls_cnt;
  // Model state for the ce-toggle run.
  int pos, exp_x, exp_y, exp_addr, bad_xy, bad_sync, bad_pulse, bad_addr, fs_c1, fs_c2;
  logic exp_ls, exp_fs, exp_hs, exp_vs, exp_de;

  initial begin
    RESET = 1'b1;
    ce    = 1'b0;
    repeat (2) @(negedge CLK);

    // Reset values, both geometries.
    check_eq("rst_full_x", f_x, 799);
    check_eq("rst_full_y", f_y, 524);
    check_eq("rst_full_hsync", f_hsync, 1);
    check_eq("rst_full_vsync", f_vsync, 1);
    check_eq("rst_full_de", f_de, 0);
    check_eq("rst_full_pulses", {f_ls, f_fs}, 0);
    check_eq("rst_full_addr", f_addr, 0);
    check_eq("rst_small_xy", {s_x, s_y}, {11'd24, 11'd8});
    check_eq("rst_small_dbg_states", {s_dbg_h, s_dbg_v}, 4'b1111);

    // Continuous ce: position p is the p-th ce cycle after reset release.
    RESET = 1'b0;
    ce    = 1'b1;
    f_de_cnt = 0; f_hs_first = -1; f_hs_cnt = 0; f_ls2 = -1;
    s_fs2 = -1; s_fs_cnt = 0; s_vs_first = -1; s_vs_cnt = 0;
    s_de_cnt = 0; s_de_blank = 0; s_ls_cnt = 0;
    for (int p = 0; p < 900; p++) begin
      @(negedge CLK);
      if (p == 0) begin
        check_eq("first_full_xy", {f_x, f_y}, 0);
        check_eq("first_full_de", f_de, 1);
        check_eq("first_full_pulses", {f_ls, f_fs}, 2'b11);
        check_eq("first_full_addr", f_addr, 0);
        check_eq("first_small_pulses", {s_ls, s_fs, s_de}, 3'b111);
      end
      if (p == 639) check_eq("addr_x639_y0", f_addr, 639);
      if (p == 700) check_eq("addr_held_hblank", f_addr, 639);
      if (p == 800) begin
        check_eq("addr_x0_y1", f_addr, 640);
        check_eq("full_y_after_wrap", f_y, 1);
      end
      if (p == 90)  check_eq("small_addr_last_pixel", s_addr, 63);
      if (p == 224) check_eq("small_addr_held_vblank", s_addr, 63);
      if (p == 225) check_eq("small_addr_next_frame", s_addr, 0);
`ifdef VGA_TEST_PATTERN_EN
      if (p == 3)   check_eq("rgb_small_yellow", s_rgb, 16'hFFE0);
      if (p == 10)  check_eq("rgb_small_red", s_rgb, 16'hF800);
      if (p == 13)  check_eq("rgb_small_blue", s_rgb, 16'h001F);
      if (p == 16)  check_eq("rgb_small_blank", s_rgb, 16'h0000);
      if (p == 80)  check_eq("rgb_full_yellow", f_rgb, 16'hFFE0);
      if (p == 400) check_eq("rgb_full_red", f_rgb, 16'hF800);
`endif
      if (p < 800) begin
        if (f_de) f_de_cnt++;
        if (!f_hsync) begin
          f_hs_cnt++;
          if (f_hs_first < 0) f_hs_first = p;
        end
      end
      if (p > 0 && f_ls && f_ls2 < 0) f_ls2 = p;
      if (p > 0 && s_fs && s_fs2 < 0) s_fs2 = p;
      if (p < 450 && s_fs) s_fs_cnt++;
      if (p < 225) begin
        if (s_de) s_de_cnt++;
        if (s_ls) s_ls_cnt++;
        if (!s_vsync) begin
          s_vs_cnt++;
          if (s_vs_first < 0) s_vs_first = p;
        end
      end
      if (s_de && s_y >= 11'(SM_VSIZE)) s_de_blank++;
    end
    check_eq("full_de_cycles_line0", f_de_cnt, 640);
    check_eq("full_hsync_first_low", f_hs_first, 656);
    check_eq("full_hsync_low_cycles", f_hs_cnt, 96);
    check_eq("full_line_start_period", f_ls2, 800);
    check_eq("small_frame_period", s_fs2, 225);
    check_eq("small_frame_start_count", s_fs_cnt, 2);
    check_eq("small_vsync_first_low", s_vs_first, 125);
    check_eq("small_vsync_low_cycles", s_vs_cnt, 50);
    check_eq("small_de_cycles_frame", s_de_cnt, 64);
    check_eq("small_de_in_vblank", s_de_blank, 0);
    check_eq("small_line_starts_frame", s_ls_cnt, 9);

    // ce toggling 1/0: small instance against a position model.
    apply_reset();
    pos = -1; bad_xy = 0; bad_sync = 0; bad_pulse = 0; bad_addr = 0; fs_c1 = -1; fs_c2 = -1;
    for (int c = 0; c < 1000; c++) begin
      @(negedge CLK);
      if (ce) pos++;
      exp_x  = pos % SM_HT;
      exp_y  = (pos / SM_HT) % SM_VT;
      exp_ls = ce && (exp_x == 0);
      exp_fs = exp_ls && (exp_y == 0);
      exp_hs = !(exp_x >= 18 && exp_x < 21);
      exp_vs = !(exp_y >= 5 && exp_y < 7);
      exp_de = (exp_x < SM_HSIZE) && (exp_y < SM_VSIZE);
      if (exp_y < SM_VSIZE) exp_addr = exp_y * SM_HSIZE + ((exp_x < SM_HSIZE) ? exp_x : SM_HSIZE - 1);
      else                  exp_addr = SM_HSIZE * SM_VSIZE - 1;
      if (s_x !== 11'(exp_x) || s_y !== 11'(exp_y)) bad_xy++;
      if (s_hsync !== exp_hs || s_vsync !== exp_vs || s_de !== exp_de) bad_sync++;
      if (s_ls !== exp_ls || s_fs !== exp_fs) bad_pulse++;
      if (s_addr !== 24'(exp_addr)) bad_addr++;
      if (s_fs === 1'b1) begin
        if (fs_c1 < 0) fs_c1 = c;
        else if (fs_c2 < 0) fs_c2 = c;
      end
      ce = ~ce;
    end
    check_eq("ce_toggle_xy_errs", bad_xy, 0);
    check_eq("ce_toggle_sync_de_errs", bad_sync, 0);
    check_eq("ce_toggle_pulse_errs", bad_pulse, 0);
    check_eq("ce_toggle_addr_errs", bad_addr, 0);
    check_eq("ce_toggle_first_fs", fs_c1, 0);
    check_eq("ce_toggle_frame_period", fs_c2 - fs_c1, 450);

    // Reset while the small raster is inside both sync pulses (x=19, y=5).
    apply_reset();
    for (int p = 0; p <= 144; p++) @(negedge CLK);
    check_eq("pre_rst_small_xy", {s_x, s_y}, {11'd19, 11'd5});
    check_eq("pre_rst_small_syncs", {s_hsync, s_vsync}, 2'b00);
    ce    = 1'b0;
    RESET = 1'b1;
    #1;
    check_eq("mid_rst_small_syncs", {s_hsync, s_vsync}, 2'b11);
    check_eq("mid_rst_small_xy", {s_x, s_y}, {11'd24, 11'd8});
    check_eq("mid_rst_small_de_addr", {s_de, s_addr}, 25'd0);
    check_eq("mid_rst_full_x", f_x, 799);
    @(negedge CLK);
    RESET = 1'b0;
    ce    = 1'b1;
    @(negedge CLK);
    check_eq("restart_small_xy", {s_x, s_y}, 0);
    check_eq("restart_small_pulses_de", {s_ls, s_fs, s_de}, 3'b111);
    check_eq("restart_small_addr", s_addr, 0);
    check_eq("restart_full_fs", f_fs, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
